pipe_fixedpointacc: RTL and testbench
=====================================

// Module: pipe_FixedPointAcc
// PURPOSE
// - Frame accumulator that sits downstream of the 2-stage fixed-point multiplier.
// - Sums a stream of signed fixed-point products into a dot-product result, one result per frame.
// - Frames are delimited by in_last or by reaching MAXLEN samples.
// - Result is converted to the WOI.WOF output format, with optional saturation and rounding.
// PARAMETERS
// - WII    16   integer bits of input (multiplier result WRI)
// - WIF    16   fraction bits of input (multiplier result WRF)
// - WG     4    guard integer bits added to the internal accumulator
// - WOI    8    output integer bits
// - WOF    8    output fraction bits
// - ROOF   1    1: saturate output on overflow; 0: wrap (drop MSBs)
// - ROUND  1    1: round half-up when WOF<WIF; 0: truncate toward -inf
// - MAXLEN 256  max samples per frame (>=1)
// PORTS
// - clk       in   1              clock, all logic on posedge
// - rst       in   1              reset, synchronous, active-high
// - clear     in   1              sync abort of current frame, no result emitted
// - in_valid  in   1              sample valid (no backpressure; every valid sample is consumed)
// - in_last   in   1              qualifies in_valid: final sample of frame
// - in        in   WII+WIF        signed two's-complement sample
// - out_valid out  1              1-cycle pulse: result valid
// - out       out  WOI+WOF        signed result
// - count     out  $clog2(MAXLEN+1)  samples in the emitted frame
// - upflow    out  1              result exceeded positive range (accumulator or output)
// - downflow  out  1              result exceeded negative range (accumulator or output)
// - overrun   out  1              frame closed by MAXLEN, not by in_last
// - busy      out  1              frame in progress (at least 1 sample accumulated, not yet emitted)
// BEHAVIOUR
// - Reset: all outputs 0; accumulator 0; sticky flags 0; sample counter 0; state IDLE.
// - State IDLE: on in_valid, the accumulator loads sign-extended in and the counter is set to 1.
//   - Go to ACC, unless the frame closes on this sample (in_last or MAXLEN==1).
// - State ACC: on in_valid, acc <= sat(acc + in) and the counter increments.
// - Frame close: in_valid && (in_last || counter+1==MAXLEN).
//   - Final sum is included.
//   - Next cycle: out_valid=1 with out/count/flags; state returns to IDLE.
//   - Latency: 1 cycle from the closing sample to out_valid.
// - Back-to-back frames: the sample in the cycle after a close starts a new frame from zero.
//   - No idle cycle is required; out_valid of the old frame coincides with the first add of the new frame.
// - Accumulator: WA = WII+WG integer bits, WIF fraction bits, signed.
//   - Each sum is computed at WA+1 bits.
//   - If the sum exceeds the WA range, acc clamps to max/min and sets sticky pos_sat/neg_sat.
//   - Sticky flags clear on frame start.
// - Output conversion of the final acc:
//   - Fraction, WOF<WIF: with ROUND=1, add 2^(WIF-WOF-1) before truncating; the rounding add itself may overflow and is range-checked.
//   - Fraction, WOF>=WIF: zero-pad.
//   - Integer: sign-extend or range-check into WOI.
//   - If out of range: ROOF=1 gives max (0111..1) or min (1000..0); ROOF=0 drops MSBs.
//   - upflow = pos_sat | positive out-of-range; downflow = neg_sat | negative out-of-range.
//   - Flags are reported in both ROOF modes.
// - overrun=1 only when the close was caused by MAXLEN with in_last=0.
// - clear has priority over in_valid in the same cycle:
//   - acc, counter and sticky flags go to 0; state goes to IDLE; busy goes to 0.
//   - The pending sample is dropped and no out_valid is produced.
//   - A result already registered (out_valid this cycle) is unaffected.
// - rst mid-frame: same as clear, plus all outputs go to 0.
// - in_last without in_valid is ignored.
// - out/count/flags hold their last values while out_valid=0.
// TESTING (WII=16,WIF=16,WG=4,WOI=8,WOF=8,ROOF=1,ROUND=1 unless stated)
// - Samples 0x0001_8000, 0x0002_4000, 0xFFFF_4000(last) (1.5+2.25-0.75)
//   -> 1 cycle after last: out_valid=1, out=0x0300, count=3, flags 0.
// - Single sample 0x0000_0080 with last -> out=0x0001.
//   - Same with ROUND=0 -> out=0x0000.
// - Samples 0x0064_0000, 0x0064_0000(last) (100+100) -> out=0x7FFF, upflow=1.
//   - Same with ROOF=0 -> out=0xC800, upflow=1.
// - MAXLEN=4: 5 samples of 0x0001_0000, no last
//   -> out_valid after 4th: out=0x0400, count=4, overrun=1.
//   - 5th sample starts a new frame; busy=1.
// - Frame A closes (last) and frame B's first sample arrives the next cycle
//   -> A result correct; B sum excludes A.
//   - clear on B's 2nd sample -> no B output; next frame starts from 0.
// - rst asserted mid-frame after 2 samples -> all outputs 0 next cycle.
//   - The subsequent 1-sample frame 0x0002_0000 -> out=0x0200, count=1.

Source files
------------

// File: rtl/pipe_fixedpointacc.sv
// rtl/pipe_fixedpointacc.sv - frame accumulator for signed fixed-point products
// Sums a sample stream per frame with saturation, then rounds/range-checks into WOI.WOF.
module pipe_fixedpointacc #(
  parameter int WII    = 16,
  parameter int WIF    = 16,
  parameter int WG     = 4,
  parameter int WOI    = 8,
  parameter int WOF    = 8,
  parameter int ROOF   = 1,
  parameter int ROUND  = 1,
  parameter int MAXLEN = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [WII+WIF-1:0]           in,
  output logic                         out_valid,
  output logic [WOI+WOF-1:0]           out,
  output logic [$clog2(MAXLEN+1)-1:0]  count,
  output logic                         upflow,
  output logic                         downflow,
  output logic                         overrun,
  output logic                         busy
);

  localparam int WIN  = WII + WIF;
  localparam int WA   = WII + WG;
  localparam int WACC = WA + WIF;
  localparam int WO   = WOI + WOF;
  localparam int WR   = WA + 1 + WOF;
  localparam int CW   = $clog2(MAXLEN + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_ACC  = 1'b1;

  logic            r_state;
  logic [WACC-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_pos_sat;
  logic            r_neg_sat;
  logic            r_out_valid;
  logic [WO-1:0]   r_out;
  logic [CW-1:0]   r_count;
  logic            r_upflow;
  logic            r_downflow;
  logic            r_overrun;

  logic [WACC:0]   w_base;
  logic [WACC:0]   w_in_ext;
  logic [WACC:0]   w_sum;
  logic            w_pos_sat;
  logic            w_neg_sat;
  logic [WACC-1:0] w_acc_nxt;
  logic            w_pos_flag;
  logic            w_neg_flag;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_close;
  logic [WR-1:0]   w_scaled;
  logic            w_opos;
  logic            w_oneg;
  logic [WO-1:0]   w_out_conv;

  // In IDLE the base is zero so the first sample simply loads the accumulator.
  assign w_base     = (r_state == S_ACC) ? {r_acc[WACC-1], r_acc} : '0;
  assign w_in_ext   = {{(WACC + 1 - WIN){in[WIN-1]}}, in};
  assign w_sum      = w_base + w_in_ext;
  assign w_pos_sat  = ~w_sum[WACC] & w_sum[WACC-1];
  assign w_neg_sat  = w_sum[WACC] & ~w_sum[WACC-1];
  assign w_acc_nxt  = w_pos_sat ? {1'b0, {(WACC-1){1'b1}}} :
                      w_neg_sat ? {1'b1, {(WACC-1){1'b0}}} : w_sum[WACC-1:0];
  assign w_pos_flag = ((r_state == S_ACC) & r_pos_sat) | w_pos_sat;
  assign w_neg_flag = ((r_state == S_ACC) & r_neg_sat) | w_neg_sat;
  assign w_cnt_nxt  = ((r_state == S_ACC) ? r_cnt : '0) + CW'(1);
  assign w_close    = in_valid & (in_last | (w_cnt_nxt == CW'(MAXLEN)));

  if (WOF < WIF) begin : g_shr
    localparam int SH = WIF - WOF;
    logic [WACC:0] w_half;
    logic [WACC:0] w_rnd;
    logic          w_unused_lsb;
    // One extra bit keeps the rounding carry; the range check below catches it.
    assign w_half       = (ROUND != 0) ? ({{WACC{1'b0}}, 1'b1} << (SH - 1)) : '0;
    assign w_rnd        = {w_acc_nxt[WACC-1], w_acc_nxt} + w_half;
    assign w_scaled     = w_rnd[WACC:SH];
    assign w_unused_lsb = ^w_rnd[SH-1:0];
  end else if (WOF == WIF) begin : g_same
    assign w_scaled = {w_acc_nxt[WACC-1], w_acc_nxt};
  end else begin : g_shl
    assign w_scaled = {w_acc_nxt[WACC-1], w_acc_nxt, {(WOF - WIF){1'b0}}};
  end

  if (WR > WO) begin : g_rng
    assign w_opos = ~w_scaled[WR-1] & (|w_scaled[WR-2:WO-1]);
    assign w_oneg = w_scaled[WR-1] & ~(&w_scaled[WR-2:WO-1]);
    if (ROOF != 0) begin : g_sat
      assign w_out_conv = w_opos ? {1'b0, {(WO-1){1'b1}}} :
                          w_oneg ? {1'b1, {(WO-1){1'b0}}} : w_scaled[WO-1:0];
    end else begin : g_wrap
      assign w_out_conv = w_scaled[WO-1:0];
    end
  end else if (WR == WO) begin : g_fit
    assign w_opos     = 1'b0;
    assign w_oneg     = 1'b0;
    assign w_out_conv = w_scaled;
  end else begin : g_ext
    assign w_opos     = 1'b0;
    assign w_oneg     = 1'b0;
    assign w_out_conv = {{(WO - WR){w_scaled[WR-1]}}, w_scaled};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_pos_sat   <= 1'b0;
      r_neg_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_count     <= '0;
      r_upflow    <= 1'b0;
      r_downflow  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (clear) begin
        r_state   <= S_IDLE;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_pos_sat <= 1'b0;
        r_neg_sat <= 1'b0;
      end else if (in_valid) begin
        if (w_close) begin
          r_state     <= S_IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_pos_sat   <= 1'b0;
          r_neg_sat   <= 1'b0;
          r_out_valid <= 1'b1;
          r_out       <= w_out_conv;
          r_count     <= w_cnt_nxt;
          r_upflow    <= w_pos_flag | w_opos;
          r_downflow  <= w_neg_flag | w_oneg;
          r_overrun   <= ~in_last;
        end else begin
          r_state   <= S_ACC;
          r_acc     <= w_acc_nxt;
          r_cnt     <= w_cnt_nxt;
          r_pos_sat <= w_pos_flag;
          r_neg_sat <= w_neg_flag;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign count     = r_count;
  assign upflow    = r_upflow;
  assign downflow  = r_downflow;
  assign overrun   = r_overrun;
  assign busy      = (r_state == S_ACC);

endmodule

// File: tb/tb_pipe_fixedpointacc.sv
// tb/tb_pipe_fixedpointacc.sv - bench for pipe_fixedpointacc
// Four configurations share one stimulus stream; each is compared to an arithmetic model.
module tb_pipe_fixedpointacc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;

  logic        o_valid [4];
  logic [15:0] o_out   [4];
  logic [8:0]  o_cnt   [4];
  logic        o_up    [4];
  logic        o_dn    [4];
  logic        o_ovr   [4];
  logic        o_busy  [4];

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int ML = (g == 3) ? 4 : 256;
    logic [$clog2(ML+1)-1:0] w_c;
    pipe_fixedpointacc #(
      .WII(16), .WIF(16), .WG(4), .WOI(8), .WOF(8),
      .ROOF((g == 2) ? 0 : 1), .ROUND((g == 1) ? 0 : 1), .MAXLEN(ML)
    ) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .in(in_data), .out_valid(o_valid[g]), .out(o_out[g]), .count(w_c),
      .upflow(o_up[g]), .downflow(o_dn[g]), .overrun(o_ovr[g]), .busy(o_busy[g])
    );
    assign o_cnt[g] = 9'(w_c);
  end

  // Model state per configuration: 0 default, 1 truncate, 2 wrap, 3 MAXLEN=4
  bit          m_busy [4];
  longint      m_acc  [4];
  int          m_cnt  [4];
  bit          m_ps   [4];
  bit          m_ns   [4];
  bit          e_v    [4];
  logic [15:0] e_out  [4];
  int          e_cnt  [4];
  bit          e_up   [4];
  bit          e_dn   [4];
  bit          e_ovr  [4];

  localparam longint AMAX = 64'sd34359738367;
  localparam longint AMIN = -64'sd34359738368;

  function automatic int cfg_maxlen(input int k);
    return (k == 3) ? 4 : 256;
  endfunction

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ps[k] = 0; m_ns[k] = 0;
  endtask

  task automatic model_step(input int k, input bit r, input bit c, input bit v,
                            input bit l, input logic [31:0] d);
    longint q;
    e_v[k] = 0;
    if (r) begin
      model_reset(k);
      e_out[k] = '0; e_cnt[k] = 0; e_up[k] = 0; e_dn[k] = 0; e_ovr[k] = 0;
      return;
    end
    if (c) begin
      model_reset(k);
      return;
    end
    if (!v) return;
    if (!m_busy[k]) model_reset(k);
    m_acc[k] += longint'($signed(d));
    if (m_acc[k] > AMAX) begin m_acc[k] = AMAX; m_ps[k] = 1; end
    if (m_acc[k] < AMIN) begin m_acc[k] = AMIN; m_ns[k] = 1; end
    m_cnt[k]++;
    if (l || m_cnt[k] == cfg_maxlen(k)) begin
      q = (m_acc[k] + ((k == 1) ? 0 : 128)) >>> 8;
      e_v[k]   = 1;
      e_cnt[k] = m_cnt[k];
      e_up[k]  = m_ps[k] | (q > 32767);
      e_dn[k]  = m_ns[k] | (q < -32768);
      e_ovr[k] = !l;
      if (k != 2 && q > 32767)       e_out[k] = 16'h7FFF;
      else if (k != 2 && q < -32768) e_out[k] = 16'h8000;
      else                           e_out[k] = q[15:0];
      model_reset(k);
    end else begin
      m_busy[k] = 1;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input bit l,
                       input logic [31:0] d);
    rst = r; clear = c; in_valid = v; in_last = l; in_data = d;
    for (int k = 0; k < 4; k++) model_step(k, r, c, v, l, d);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("out_valid", k, 32'(o_valid[k]), 32'(e_v[k]));
      chk("busy",      k, 32'(o_busy[k]),  32'(m_busy[k]));
      chk("out",       k, 32'(o_out[k]),   32'(e_out[k]));
      chk("count",     k, 32'(o_cnt[k]),   32'(e_cnt[k]));
      chk("upflow",    k, 32'(o_up[k]),    32'(e_up[k]));
      chk("downflow",  k, 32'(o_dn[k]),    32'(e_dn[k]));
      chk("overrun",   k, 32'(o_ovr[k]),   32'(e_ovr[k]));
    end
  endtask

  task automatic smp(input logic [31:0] d, input bit l);
    cycle(0, 0, 1, l, d);
  endtask

  function automatic logic [31:0] rnd_sample();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 2))
      0:       return {{12{d[19]}}, d[19:0]};
      1:       return {{4{d[27]}}, d[27:0]};
      default: return d;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("reset_out", 0, 32'(o_out[0]), 32'h0);
    cycle(0, 0, 0, 0, '0);

    smp(32'h0001_8000, 0); smp(32'h0002_4000, 0); smp(32'hFFFF_4000, 1);
    chk("spec_sum_out", 0, 32'(o_out[0]), 32'h0300);
    chk("spec_sum_cnt", 0, 32'(o_cnt[0]), 32'd3);
    cycle(0, 0, 0, 0, '0);

    smp(32'h0000_0080, 1);
    chk("spec_round", 0, 32'(o_out[0]), 32'h0001);
    chk("spec_trunc", 1, 32'(o_out[1]), 32'h0000);

    smp(32'h0064_0000, 0); smp(32'h0064_0000, 1);
    chk("spec_sat",  0, 32'(o_out[0]), 32'h7FFF);
    chk("spec_wrap", 2, 32'(o_out[2]), 32'hC800);
    chk("spec_wrap_up", 2, 32'(o_up[2]), 32'h1);
    cycle(0, 0, 0, 0, '0);

    for (int i = 0; i < 4; i++) smp(32'h0001_0000, 0);
    chk("spec_maxlen_out", 3, 32'(o_out[3]), 32'h0400);
    chk("spec_maxlen_ovr", 3, 32'(o_ovr[3]), 32'h1);
    smp(32'h0001_0000, 0);
    chk("spec_maxlen_busy", 3, 32'(o_busy[3]), 32'h1);
    cycle(0, 1, 0, 0, '0);

    smp(32'h0001_0000, 0); smp(32'h0002_0000, 1);
    smp(32'h0003_0000, 0);
    chk("spec_b2b_a", 0, 32'(o_out[0]), 32'h0300);
    cycle(0, 1, 1, 0, 32'h0004_0000);
    smp(32'h0005_0000, 1);
    chk("spec_after_clear", 0, 32'(o_out[0]), 32'h0500);

    smp(32'h0001_0000, 0); smp(32'h0001_0000, 0);
    cycle(1, 0, 0, 0, '0);
    chk("spec_rst_out", 0, 32'(o_out[0]), 32'h0);
    cycle(0, 0, 0, 0, '0);
    smp(32'h0002_0000, 1);
    chk("spec_rst_next", 0, 32'(o_out[0]), 32'h0200);
    chk("spec_rst_cnt",  0, 32'(o_cnt[0]), 32'd1);

    for (int i = 0; i < 17; i++) smp(32'h7FFF_FFFF, 0);
    smp(32'h8000_0000, 1);
    chk("acc_pos_sticky", 0, 32'(o_up[0]), 32'h1);
    for (int i = 0; i < 17; i++) smp(32'h8000_0000, 0);
    smp(32'h8000_0000, 1);
    chk("acc_neg_sat", 0, 32'(o_dn[0]), 32'h1);

    cycle(0, 0, 0, 1, 32'h0001_0000);
    cycle(0, 0, 0, 0, '0);

    for (int i = 0; i < 1500; i++) begin
      cycle(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), rnd_sample());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
